// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types, widths and helpers for the seven-segment scan controller.
// Imported by seg_slot_timer and seg_scan_ctrl.
package seg_scan_pkg;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;

  localparam int IDX_W = 3;
  localparam int NIB_W = 4;

  // Next digit index in scan order, wrapping after the last digit.
  function automatic logic [IDX_W-1:0] next_digit(
    input logic [IDX_W-1:0] cur,
    input int               digits
  );
    if (int'(cur) >= digits - 1) return '0;
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: free-running digit-slot counter for the scan controller.
// Strobes are combinational decodes of the registered count.
module seg_slot_timer
  import seg_scan_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic slot_start,
  output logic slot_last,
  output logic blank_done
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1 and wrap.
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (cnt == TOP) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  // Final cycle of a slot: the next slot starts on the coming edge.
  assign slot_start = (cnt == TOP);
  // Second-to-last cycle: lets registered outputs land on the final cycle.
  assign slot_last  = (cnt == CW'(TICK_DIV - 2));
  // Final cycle of the anti-ghosting guard window.
  assign blank_done = (cnt == CW'(BLANK_CYC - 1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered multi-digit seven-segment scan controller.
// Define SEG_SCAN_BLANK_EN to add a blanking guard at the start of each slot.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [NIB_W-1:0]  wr_data,
  input  logic [DIGITS-1:0] en_mask,
  output logic [NIB_W-1:0]  d,
  output logic [IDX_W-1:0]  an,
  output logic              an_valid,
  output logic              frame_tick
);

  localparam int SW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

`ifdef SEG_SCAN_BLANK_EN
  localparam bit          BLANK_ON = 1'b1;
  localparam scan_state_t RST_ST   = BLANK;
`else
  localparam bit          BLANK_ON = 1'b0;
  localparam scan_state_t RST_ST   = SHOW;
`endif

  logic slot_start;
  logic slot_last;
  logic blank_done;
  logic commit;
  logic frame_end_nxt;
  logic wr_fire;

  logic [DIGITS-1:0][NIB_W-1:0] shadow;
  logic [DIGITS-1:0][NIB_W-1:0] disp;
  logic [DIGITS-1:0][NIB_W-1:0] disp_nxt;

  logic [IDX_W-1:0] an_nxt;
  scan_state_t      state;
  scan_state_t      state_nxt;

  seg_slot_timer #(
    .TICK_DIV  (TICK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .slot_start (slot_start),
    .slot_last  (slot_last),
    .blank_done (blank_done)
  );

  assign commit        = slot_start && (an == LAST);
  assign frame_end_nxt = slot_last && (an == LAST);
  assign an_nxt        = slot_start ? next_digit(an, DIGITS) : an;
  assign disp_nxt      = commit ? shadow : disp;
  assign wr_fire       = wr_valid && wr_ready
                      && (int'(wr_idx) < DIGITS);

  // Slot state: guard window first (when built in), then lit.
  always_comb begin
    state_nxt = state;
    if (slot_start && BLANK_ON) state_nxt = BLANK;
    else if (blank_done) state_nxt = SHOW;
  end

  // Shadow takes producer writes; display bank loads whole at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      disp   <= '0;
    end else begin
      if (wr_fire) shadow[wr_idx[SW-1:0]] <= wr_data;
      disp <= disp_nxt;
    end
  end

  // Scan FSM with registered digit select, value and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RST_ST;
      an         <= '0;
      d          <= '0;
      an_valid   <= 1'b0;
      frame_tick <= 1'b0;
      wr_ready   <= 1'b0;
    end else begin
      state      <= state_nxt;
      an         <= an_nxt;
      d          <= disp_nxt[an_nxt[SW-1:0]];
      an_valid   <= (state_nxt == SHOW)
                 && en_mask[an_nxt[SW-1:0]];
      frame_tick <= frame_end_nxt;
      wr_ready   <= !frame_end_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (4 digits, 8-cycle slots).
// Expected per-slot records are queued with stimulus; a monitor checks each slot.
module tb_seg_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int TICK_DIV  = 8;
  localparam int BLANK_CYC = 2;
`ifdef SEG_SCAN_BLANK_EN
  localparam int BL = BLANK_CYC;
`else
  localparam int BL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_idx = '0;
  logic [3:0]  wr_data = '0;
  logic [3:0]  en_mask = 4'hF;
  logic [3:0]  d;
  logic [2:0]  an;
  logic        an_valid;
  logic        frame_tick;

  seg_scan_ctrl #(
    .DIGITS    (DIGITS),
    .TICK_DIV  (TICK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .en_mask    (en_mask),
    .d          (d),
    .an         (an),
    .an_valid   (an_valid),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] an;
    logic [3:0] d;
    logic [7:0] lit;
    logic [7:0] rdy;
    logic [7:0] tick;
  } slot_t;

  slot_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_on = 1'b0;
  bit    have = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Bit i of each pattern is the value in cycle i of the slot.
  function automatic slot_t mk(input int a, input int v,
                               input bit on, input bit first);
    slot_t s;
    s.an   = 3'(a);
    s.d    = 4'(v);
    if (!on) s.lit = 8'h00;
    else if (BL > 0) s.lit = 8'hFC;
    else s.lit = first ? 8'hFE : 8'hFF;
    s.rdy  = (first ? 8'hFE : 8'hFF) & ((a == 3) ? 8'h7F : 8'hFF);
    s.tick = (a == 3) ? 8'h80 : 8'h00;
    return s;
  endfunction

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    mon_on = 1'b0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    have = 1'b0;
    mon_on = 1'b1;
    nstep();
    chk("rst d", int'(d), 0);
    chk("rst an", int'(an), 0);
    chk("rst an_valid", int'(an_valid), 0);
    chk("rst frame_tick", int'(frame_tick), 0);
    chk("rst wr_ready", int'(wr_ready), 0);
  endtask

  task automatic wr(input logic [2:0] i, input logic [3:0] v);
    int n = 0;
    wr_valid = 1'b1;
    wr_idx = i;
    wr_data = v;
    while (!wr_ready && n < 64) begin
      nstep();
      n++;
    end
    chk("wr_accept", int'(wr_ready), 1);
    nstep();
    wr_valid = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (((cyc - 1) % 32) != p && n < 100) begin
      nstep();
      n++;
    end
    chk("wait_pos", (cyc - 1) % 32, p);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (!(exp_q.size() == 0 && !have) && n < max) begin
      nstep();
      n++;
    end
    chk("drain_left", exp_q.size() + int'(have), 0);
  endtask

  // Slot monitor: pops a record at slot start, compares at slot end.
  initial begin : monitor
    slot_t      e;
    logic [7:0] litp;
    logic [7:0] rdyp;
    logic [7:0] tickp;
    int         an_got;
    int         d_got;
    int         sn;
    int         p;
    sn = 0;
    an_got = 0;
    d_got = 0;
    litp = '0;
    rdyp = '0;
    tickp = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        p = cyc % 8;
        if (p == 0) begin
          have = exp_q.size() > 0;
          if (have) begin
            e = exp_q.pop_front();
            an_got = int'(an);
            d_got = int'(d);
          end
        end
        if (have) begin
          if (an != e.an) an_got = int'(an);
          if (d != e.d) d_got = int'(d);
          litp[p[2:0]]  = an_valid;
          rdyp[p[2:0]]  = wr_ready;
          tickp[p[2:0]] = frame_tick;
          if (p == 7) begin
            chk($sformatf("slot%0d an", sn), an_got, int'(e.an));
            chk($sformatf("slot%0d d", sn), d_got, int'(e.d));
            chk($sformatf("slot%0d an_valid", sn),
                int'(litp), int'(e.lit));
            chk($sformatf("slot%0d wr_ready", sn),
                int'(rdyp), int'(e.rdy));
            chk($sformatf("slot%0d frame_tick", sn),
                int'(tickp), int'(e.tick));
            have = 1'b0;
            sn++;
          end
        end
        cyc++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    int n;
    int blocked;
    int dv[12];

    // Frame 0 shows the reset bank; frame 1 the first four writes.
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 4; s++)
        exp_q.push_back(mk(s, (f == 0) ? 0 : s + 1, 1'b1,
                           f == 0 && s == 0));
    do_reset(2);
    for (int i = 0; i < 4; i++) wr(3'(i), 4'(i + 1));
    wait_drain(100);

    // Frames 2..4: mask 1010, streaming across a commit, dropped index.
    en_mask = 4'b1010;
    dv = '{1, 2, 3, 4, 8, 9, 10, 4, 12, 13, 14, 11};
    for (int j = 0; j < 12; j++)
      exp_q.push_back(mk(j % 4, dv[j], (j % 2) == 1, 1'b0));
    wait_pos(28);
    k = 0;
    n = 0;
    blocked = 0;
    while (k < 7 && n < 40) begin
      wr_valid = 1'b1;
      wr_idx = 3'(k % 4);
      wr_data = 4'(8 + k);
      if (wr_ready) k++;
      else blocked++;
      nstep();
      n++;
    end
    wr_valid = 1'b0;
    chk("stream_blocked", blocked, 1);
    chk("stream_count", k, 7);
    wait_pos(8);
    wr(3'd5, 4'hF);
    wait_drain(200);

    // Pending write then reset mid slot 2: both banks come back zero.
    wr(3'd0, 4'd7);
    wait_pos(18);
    en_mask = 4'hF;
    for (int j = 0; j < 8; j++)
      exp_q.push_back(mk(j % 4, 0, 1'b1, j == 0));
    do_reset(1);
    wait_drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's multi-digit seven-segment display. It owns the per-digit nibble registers, accepts digit updates from any producer over a valid/ready write port, and sequences digit select (`an`) and digit value (`d`) so each digit is driven for a fixed slot. Writes are double-buffered and committed at frame boundaries, so the display never tears. It sits between datapath producers and the external hex-to-segment decoder.

## Interface
- DIGITS, 8, number of scanned digits (2..8)
- TICK_DIV, 100000, clk cycles per digit slot
- BLANK_CYC, 1000, guard cycles at slot start when blanking is compiled in; must satisfy BLANK_CYC < TICK_DIV
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  producer offers a digit write
- wr_ready  out  1  controller accepts the write this cycle
- wr_idx  in  3  target digit index
- wr_data  in  4  nibble for that digit
- en_mask  in  DIGITS  per-digit enable; a 0 bit blanks that digit's slot
- d  out  4  nibble of the currently selected digit
- an  out  3  index of the currently selected digit
- an_valid  out  1  high while the selected digit should be lit
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame

## Operation
- Two banks of DIGITS×4 bits: shadow (written by the port) and display (drives `d`). Both reset to 0.
- A write is accepted when wr_valid && wr_ready: shadow[wr_idx] <= wr_data. If wr_idx >= DIGITS, the write is accepted and dropped.
- Slot counter runs 0..TICK_DIV-1. The slot index runs 0..DIGITS-1 and wraps to 0.
- At slot end, the index advances. When the index is DIGITS-1, frame_tick=1 and the whole shadow bank is copied to the display bank in that cycle. wr_ready=0 in that cycle only, so no write can collide with the commit.
- State machine: BLANK -> SHOW -> BLANK (next slot). BLANK lasts BLANK_CYC cycles and SHOW the remainder. BLANK exists only with the macro; otherwise the block stays in SHOW.
- an_valid = (state==SHOW) && en_mask[an].
- en_mask is sampled every cycle; a change takes effect on the next registered output.
- Reset mid-frame: everything returns to reset values, pending shadow writes are lost, and the scan restarts at slot 0.

## Timing
- All outputs are registered.
- Reset values: d=0, an=0, an_valid=0, frame_tick=0, wr_ready=0. wr_ready rises the first cycle after rst deasserts.
- `an` and `d` update one cycle after the slot-counter wrap.
- `d` shows the newly committed bank starting at slot 0 of the next frame.
- Write-to-display latency is at most one frame plus one cycle; a written value never appears mid-frame.
- Frame period is DIGITS*TICK_DIV cycles exactly, independent of write traffic and en_mask.
- Back-to-back writes are accepted every cycle except the frame_tick cycle. A later write to the same index overwrites the earlier one.

## Configuration
- SEG_SCAN_BLANK_EN defined: each slot starts with BLANK_CYC cycles of an_valid=0 while `an` and `d` already hold the new digit. This is the anti-ghosting guard.
- SEG_SCAN_BLANK_EN undefined: no BLANK state, an_valid=en_mask[an] for the whole slot, and BLANK_CYC is ignored.

## Structure
- Package seg_scan_pkg:
  - scan state enum (BLANK, SHOW)
  - digit-index width constant (3)
  - nibble width constant (4)
- Sub-module seg_slot_timer: TICK_DIV counter emitting slot_start and blank_done strobes, with synchronous reset.
- Top level holds the banks, index, FSM, and handshake.

## Test plan
- Params DIGITS=4, TICK_DIV=8, BLANK_CYC=2, macro off. Release reset, then write idx0..3 = 1,2,3,4 -> d stays 0 for frame 0; frame 1 shows an 0,1,2,3 with d 1,2,3,4, each held 8 cycles; frame_tick pulses every 32 cycles.
- Hold wr_valid high continuously -> wr_ready=0 exactly on each frame_tick cycle and 1 otherwise; no write is lost or duplicated.
- Macro on -> each slot shows an_valid=0 for 2 cycles then 1 for 6 cycles; `an` changes at the blank start.
- en_mask=4'b1010 -> an_valid is never 1 while an=0 or an=2; frame period is still 32 cycles.
- Write idx=5 with data F -> accepted, and no display digit changes.
- Assert rst for 1 cycle mid-slot 2 -> next cycle all outputs are at reset values, the scan restarts at an=0, and the display bank is 0.
